// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter between ALU and load results, with a register
// scoreboard that stalls decode on outstanding destinations.
module regfile_wb_scheduler (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  query_rs1,
    input  logic [4:0]  query_rs2,
    input  logic        flush,
    output logic        stall,
    output logic        rf_write_enable,
    output logic [4:0]  rf_addr_rd,
    output logic [31:0] rf_data_rd
);

    logic        ptr_q, ptr_d;
    logic [31:0] busy_q, busy_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        alu_go, mem_go, xfer;
    logic [4:0]  rd_sel;
    logic [31:0] data_sel;

    // ptr_q=0 prefers ALU, 1 prefers MEM; a lone requester always wins
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!reset) begin
            alu_ready = alu_valid && (!mem_valid || !ptr_q);
            mem_ready = mem_valid && (!alu_valid || ptr_q);
        end
    end

    assign alu_go = alu_valid && alu_ready;
    assign mem_go = mem_valid && mem_ready;
    assign xfer   = alu_go || mem_go;

    always_comb begin
        rd_sel   = 5'd0;
        data_sel = 32'd0;
        unique case (1'b1)
            alu_go: begin
                rd_sel   = alu_rd;
                data_sel = alu_data;
            end
            mem_go: begin
                rd_sel   = mem_rd;
                data_sel = mem_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            stall = busy_q[query_rs1] || busy_q[query_rs2]
                 || (issue_valid && busy_q[issue_rd]);
        end
    end

    always_comb begin
        ptr_d  = ptr_q ^ xfer;
        we_d   = xfer && (rd_sel != 5'd0);
        addr_d = xfer ? rd_sel : addr_q;
        data_d = xfer ? data_sel : data_q;
        busy_d = busy_q;
        // Clear first so a coinciding issue to the same register wins
        if (we_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (issue_valid && !stall) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = 32'd0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q  <= 1'b0;
            busy_q <= 32'd0;
            we_q   <= 1'b0;
            addr_q <= 5'd0;
            data_q <= 32'd0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_addr_rd      = addr_q;
    assign rf_data_rd      = data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: grants, writeback port
// and stall behaviour checked against a small reference model.
module tb_regfile_wb_scheduler;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic        flush;
    logic        stall;
    logic        rf_write_enable;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;

    regfile_wb_scheduler dut (
        .clock           (clock),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .mem_valid       (mem_valid),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .query_rs1       (query_rs1),
        .query_rs2       (query_rs2),
        .flush           (flush),
        .stall           (stall),
        .rf_write_enable (rf_write_enable),
        .rf_addr_rd      (rf_addr_rd),
        .rf_data_rd      (rf_data_rd)
    );

    typedef struct {
        int unsigned cyc;
        logic [4:0]  rd;
        logic [31:0] d;
    } wb_t;

    wb_t         sb[$];
    wb_t         e;
    int          vectors = 0;
    int          errors  = 0;
    int unsigned cyc     = 0;
    logic        ptr_m   = 1'b0;
    logic        exp_we;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        while (sb.size() != 0 && sb[0].cyc < cyc) begin
            check_eq("wb_missing", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        exp_we = (sb.size() != 0) && (sb[0].cyc == cyc);
        check_eq("rf_we", {31'd0, rf_write_enable}, {31'd0, exp_we});
        if (exp_we) begin
            e = sb.pop_front();
            if (rf_write_enable) begin
                check_eq("rf_addr", {27'd0, rf_addr_rd}, {27'd0, e.rd});
                check_eq("rf_data", rf_data_rd, e.d);
            end
        end
    end

    task automatic step(input logic rst,
                        input logic av, input logic [4:0] ard,
                        input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd,
                        input logic [31:0] md,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic fl, input logic exp_stall);
        logic ag, mg;
        reset = rst;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        issue_valid = iv; issue_rd = ird;
        query_rs1 = r1; query_rs2 = r2;
        flush = fl;
        #1;
        ag = !rst && av && (!mv || !ptr_m);
        mg = !rst && mv && (!av || ptr_m);
        check_eq("alu_ready", {31'd0, alu_ready}, {31'd0, ag});
        check_eq("mem_ready", {31'd0, mem_ready}, {31'd0, mg});
        check_eq("stall", {31'd0, stall}, {31'd0, exp_stall});
        if (ag) begin
            if (ard != 5'd0) sb.push_back('{cyc + 1, ard, ad});
            ptr_m = !ptr_m;
        end else if (mg) begin
            if (mrd != 5'd0) sb.push_back('{cyc + 1, mrd, md});
            ptr_m = !ptr_m;
        end
        if (rst) ptr_m = 1'b0;
        @(negedge clock);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2,
                        input logic exp_stall);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 0, exp_stall);
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        issue_valid = 0; issue_rd = 0;
        query_rs1 = 0; query_rs2 = 0; flush = 0;
        @(negedge clock);
        step(1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5'd1, 32'h1, 0, 0, 0, 1, 5'd3, 5'd3, 0, 0, 0);
        check_eq("rst_addr", {27'd0, rf_addr_rd}, 32'd0);
        check_eq("rst_data", rf_data_rd, 32'd0);

        // ALU first, then MEM
        step(0, 1, 5'd5, 32'hA5A5_0005, 1, 5'd6, 32'hA6A6_0006, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5'd5, 32'hA5A5_0005, 1, 5'd6, 32'hA6A6_0006, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        // Lone requesters regardless of pointer
        step(0, 0, 0, 0, 1, 5'd8, 32'h0000_0808, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5'd1, 32'h1111_0001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // x0 writeback: handshake but no write
        step(0, 0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);

        // Busy x7 until its write commits; issue to x10 while stalled
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 5'd7, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0, 1);
        step(0, 1, 5'd7, 32'h7777_0007, 0, 0, 0, 0, 0, 5'd7, 0, 0, 1);
        idle(5'd7, 0, 1);
        idle(5'd7, 0, 0);
        idle(0, 5'd10, 0);

        // Set and clear of x9 on the same edge
        step(0, 1, 5'd9, 32'h9999_0009, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0, 0);
        idle(0, 5'd9, 1);
        step(0, 1, 5'd9, 32'h9999_000A, 0, 0, 0, 0, 0, 0, 5'd9, 0, 1);
        idle(0, 5'd9, 1);
        idle(0, 5'd9, 0);

        // Flush: clears busy, overrides issue, keeps in-flight write
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0);
        idle(5'd3, 5'd4, 1);
        step(0, 1, 5'd11, 32'h1111_1111, 0, 0, 0, 1, 5'd12, 0, 0, 1, 0);
        idle(5'd3, 5'd4, 0);
        idle(5'd12, 0, 0);
        step(0, 1, 5'd13, 32'h1313_1313, 1, 5'd14, 32'h1414_1414, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);

        // Reset right after an ALU transfer
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd15, 0, 0, 0, 0);
        step(0, 1, 5'd16, 32'h1616_1616, 0, 0, 0, 0, 0, 5'd15, 0, 0, 1);
        step(1, 1, 5'd19, 32'h1919_1919, 1, 5'd20, 32'h2020_2020, 0, 0, 5'd15, 0, 0, 0);
        step(0, 1, 5'd17, 32'h1717_1717, 1, 5'd18, 32'h1818_1818, 0, 0, 5'd15, 0, 0, 0);
        idle(0, 0, 0);
        idle(0, 0, 0);

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
